// File: rtl/inst_fetch.sv
// inst_fetch: RV32I instruction fetch stage.
// Keeps the fetch PC, issues word-aligned requests under a credit limit,
// queues in-order responses in a prefetch FIFO and hands instructions to the
// decoder over valid/ready. A redirect flushes the FIFO and discards stale
// in-flight responses.
// Optional feature macro: IFETCH_ALIGN_CHECK_EN (misaligned redirect -> HALT).
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_misaligned
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LP_DEPTH = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;

  logic [31:0]   r_fetchPc;
  logic [31:0]   r_rspPc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_dropCnt;
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [31:0]   r_memData [DEPTH];
  logic [31:0]   r_memPc   [DEPTH];

  logic          w_reqValid;
  logic          w_reqFire;
  logic          w_rspFire;
  logic          w_rspDrop;
  logic          w_push;
  logic          w_pop;
  logic          w_misalignedRedirect;
  logic [CW:0]   w_inFlight;
  logic [CW-1:0] w_outstandingNext;
  logic [31:0]   w_redirectTarget;

  // Redirect target with the byte-offset bits forced to zero.
  assign w_redirectTarget = {redirect_pc[31:2], 2'b00};

`ifdef IFETCH_ALIGN_CHECK_EN
  assign w_misalignedRedirect = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
  // Low target bits are simply ignored when alignment checking is absent.
  logic w_unusedLowBits;
  assign w_unusedLowBits      = ^redirect_pc[1:0];
  assign w_misalignedRedirect = 1'b0;
`endif

  // Credits: FIFO entries plus requests still in flight. Keeping this below
  // DEPTH guarantees every returning response has a free FIFO slot.
  assign w_inFlight = {1'b0, r_count} + {1'b0, r_outstanding};

  assign w_reqFire = w_reqValid & imem_req_ready;

  // A response with nothing outstanding belongs to a pre-reset request.
  assign w_rspFire = imem_rsp_valid & (r_outstanding != '0);

  // Stale responses are discarded while the drop counter is non-zero.
  assign w_rspDrop = w_rspFire & (r_dropCnt != '0);

  // A same-cycle redirect also discards the response; HALT never fills.
  assign w_push = w_rspFire & (r_dropCnt == '0) & ~redirect_valid
                  & (r_state != HALT);

  assign w_pop = inst_valid & inst_ready;

  assign w_outstandingNext = r_outstanding + CW'(w_reqFire) - CW'(w_rspFire);

  // State register: BOOT is held only during reset and the first cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic: BOOT always moves on; HALT is left only by reset.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      BOOT:    w_stateNext = w_misalignedRedirect ? HALT : RUN;
      RUN:     w_stateNext = w_misalignedRedirect ? HALT : RUN;
      HALT:    w_stateNext = HALT;
      default: w_stateNext = BOOT;
    endcase
  end

  // State outputs: requests only in RUN and only while credits remain.
  always_comb begin
    w_reqValid = 1'b0;
    if ((r_state == RUN) && (w_inFlight < LP_DEPTH)) begin
      w_reqValid = 1'b1;
    end
  end

  assign imem_req_valid = w_reqValid;
  assign imem_req_addr  = r_fetchPc;

  // Fetch PC: next request address; held while the request is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetchPc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetchPc <= w_redirectTarget;
    end else if (w_reqFire) begin
      r_fetchPc <= r_fetchPc + 32'd4;
    end
  end

  // Response PC: address tagged onto the next response kept in the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspPc <= RESET_PC;
    end else if (redirect_valid) begin
      r_rspPc <= w_redirectTarget;
    end else if (w_push) begin
      r_rspPc <= r_rspPc + 32'd4;
    end
  end

  // Outstanding requests: accepted but not yet answered by memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else begin
      r_outstanding <= w_outstandingNext;
    end
  end

  // Drop counter: on redirect every request still in flight becomes stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dropCnt <= '0;
    end else if (redirect_valid) begin
      r_dropCnt <= w_outstandingNext;
    end else if (w_rspDrop) begin
      r_dropCnt <= r_dropCnt - CW'(1);
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      r_wrPtr <= r_wrPtr + AW'(w_push);
      r_rdPtr <= r_rdPtr + AW'(w_pop);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // FIFO storage: cleared on reset so the decoder sees zeros after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_memData[i] <= '0;
        r_memPc[i]   <= '0;
      end
    end else if (w_push) begin
      r_memData[r_wrPtr] <= imem_rsp_data;
      r_memPc[r_wrPtr]   <= r_rspPc;
    end
  end

  assign inst_valid = (r_count != '0);
  assign inst       = r_memData[r_rdPtr];
  assign inst_pc    = r_memPc[r_rdPtr];

`ifdef IFETCH_ALIGN_CHECK_EN
  logic r_misaligned;

  // Sticky misaligned flag: set by a misaligned redirect, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misaligned <= 1'b0;
    end else if (w_misalignedRedirect) begin
      r_misaligned <= 1'b1;
    end
  end

  assign fetch_misaligned = r_misaligned;
`else
  assign fetch_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch with an in-order memory model
// of programmable latency. Memory word for address A is A ^ 32'hA5A5_0000.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_misaligned;

  int          errCount;
  int          checkCount;
  int          cyc;
  int          memLatency;
  int          validCycles;

  logic [31:0] memAddrQ[$];
  int          memDueQ[$];
  logic [31:0] reqLog[$];
  logic [31:0] instPcLog[$];
  logic [31:0] instWordLog[$];

  inst_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst             (inst),
    .inst_pc          (inst_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rising-edge counter used to schedule memory responses.
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Memory model: a request seen before edge E is answered for edge E+latency.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        memAddrQ.delete();
        memDueQ.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end else begin
        if ((memDueQ.size() > 0) && (memDueQ[0] == cyc + 1)) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = memAddrQ[0] ^ 32'hA5A5_0000;
          void'(memAddrQ.pop_front());
          void'(memDueQ.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = '0;
        end
        if (imem_req_valid && imem_req_ready) begin
          memAddrQ.push_back(imem_req_addr);
          memDueQ.push_back(cyc + 1 + memLatency);
          reqLog.push_back(imem_req_addr);
        end
      end
    end
  end

  // Delivery monitor: logs each decoder handshake taken at the next edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && inst_valid && inst_ready) begin
        instPcLog.push_back(inst_pc);
        instWordLog.push_back(inst);
      end
    end
  end

  // Hard stop in case the sequence never completes.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: observed=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errCount++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic reqRdy, input logic instRdy,
                               input logic redir, input logic [31:0] pc);
    imem_req_ready = reqRdy;
    inst_ready     = instRdy;
    redirect_valid = redir;
    redirect_pc    = pc;
  endtask

  task automatic doReset(input int lat, input logic instRdy);
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(1'b1, instRdy, 1'b0, 32'h0);
    memLatency = lat;
    repeat (2) @(negedge clk);
    reqLog.delete();
    instPcLog.delete();
    instWordLog.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    errCount   = 0;
    checkCount = 0;
    memLatency = 1;
    rst_n      = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (2) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst_req_addr", imem_req_addr, 32'h0);
    checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_inst", inst, 32'h0);
    checkOutput("rst_inst_pc", inst_pc, 32'h0);
    checkOutput("rst_misaligned", 32'(fetch_misaligned), 32'd0);

    $display("[TB] streaming fetch, 1-cycle memory");
    rst_n = 1'b1;
    #1;
    checkOutput("boot_no_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    checkOutput("first_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("first_req_addr", imem_req_addr, 32'h0);
    @(negedge clk);
    checkOutput("second_req_addr", imem_req_addr, 32'h4);
    checkOutput("no_bypass_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    checkOutput("first_inst_valid", 32'(inst_valid), 32'd1);
    checkOutput("first_inst_pc", inst_pc, 32'h0);
    checkOutput("first_inst_word", inst, 32'hA5A5_0000);
    validCycles = 0;
    repeat (8) begin
      if (inst_valid) validCycles++;
      @(negedge clk);
    end
    checkOutput("throughput", 32'(validCycles), 32'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput("stream_pc", instPcLog[i], 32'(i * 4));
      checkOutput("stream_word", instWordLog[i], 32'hA5A5_0000 | 32'(i * 4));
    end

    $display("[TB] decoder back-pressure");
    doReset(1, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("bp_req_count", 32'(reqLog.size()), 32'd4);
    checkOutput("bp_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("bp_inst_valid", 32'(inst_valid), 32'd1);
    checkOutput("bp_head_pc", inst_pc, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (8) @(negedge clk);
    checkOutput("bp_pc0", instPcLog[0], 32'h0);
    checkOutput("bp_pc1", instPcLog[1], 32'h4);
    checkOutput("bp_pc2", instPcLog[2], 32'h8);
    checkOutput("bp_pc3", instPcLog[3], 32'hC);
    checkOutput("bp_word3", instWordLog[3], 32'hA5A5_000C);
    checkOutput("bp_pc4", instPcLog[4], 32'h10);

    $display("[TB] redirect with 3 stale requests, 3-cycle memory");
    doReset(3, 1'b1);
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("rd3_inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rd3_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("rd3_req_addr", imem_req_addr, 32'h100);
    repeat (8) @(negedge clk);
    checkOutput("rd3_first_pc", instPcLog[0], 32'h100);
    checkOutput("rd3_first_word", instWordLog[0], 32'hA5A5_0100);
    checkOutput("rd3_second_pc", instPcLog[1], 32'h104);

    $display("[TB] redirect colliding with response and accept");
    doReset(1, 1'b1);
    repeat (4) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("rdc_inst_valid", 32'(inst_valid), 32'd0);
    repeat (6) @(negedge clk);
    checkOutput("rdc_pc0", instPcLog[0], 32'h0);
    checkOutput("rdc_pc1", instPcLog[1], 32'h4);
    checkOutput("rdc_pc2", instPcLog[2], 32'h40);
    checkOutput("rdc_word2", instWordLog[2], 32'hA5A5_0040);
    checkOutput("rdc_pc3", instPcLog[3], 32'h44);

    $display("[TB] misaligned redirect");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h202);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    instPcLog.delete();
    instWordLog.delete();
`ifdef IFETCH_ALIGN_CHECK_EN
    checkOutput("mis_flag", 32'(fetch_misaligned), 32'd1);
    checkOutput("mis_req_valid", 32'(imem_req_valid), 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("mis_halt_req", 32'(imem_req_valid), 32'd0);
    checkOutput("mis_no_inst", 32'(instPcLog.size()), 32'd0);
`else
    checkOutput("mis_flag", 32'(fetch_misaligned), 32'd0);
    checkOutput("mis_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("mis_req_addr", imem_req_addr, 32'h200);
    repeat (4) @(negedge clk);
    checkOutput("mis_first_pc", instPcLog[0], 32'h200);
`endif

    $display("[TB] PC wrap and asynchronous reset");
    doReset(1, 1'b1);
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    reqLog.delete();
    instPcLog.delete();
    instWordLog.delete();
    repeat (6) @(negedge clk);
    checkOutput("wrap_req0", reqLog[0], 32'hFFFF_FFF8);
    checkOutput("wrap_req1", reqLog[1], 32'hFFFF_FFFC);
    checkOutput("wrap_req2", reqLog[2], 32'h0);
    checkOutput("wrap_pc0", instPcLog[0], 32'hFFFF_FFF8);
    checkOutput("wrap_pc1", instPcLog[1], 32'hFFFF_FFFC);
    checkOutput("wrap_pc2", instPcLog[2], 32'h0);
    checkOutput("wrap_word0", instWordLog[0], 32'h5A5A_FFF8);
    checkOutput("wrap_busy", 32'(inst_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("arst_req_addr", imem_req_addr, 32'h0);
    checkOutput("arst_inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("arst_inst", inst, 32'h0);
    checkOutput("arst_inst_pc", inst_pc, 32'h0);
    checkOutput("arst_misaligned", 32'(fetch_misaligned), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
